// File: rtl/vga_board_pkg.sv
// Shared timing constants, cell encoding and colour masks for the VGA board painter.
package vga_board_pkg;

    localparam int H_VIS = 640;
    localparam int H_FP  = 16;
    localparam int H_SP  = 96;
    localparam int H_BP  = 48;
    localparam int H_TOT = H_VIS + H_FP + H_SP + H_BP;

    localparam int V_VIS = 480;
    localparam int V_FP  = 10;
    localparam int V_SP  = 2;
    localparam int V_BP  = 33;
    localparam int V_TOT = V_VIS + V_FP + V_SP + V_BP;

    typedef enum logic [1:0] {
        EMPTY  = 2'b00,
        MARK_X = 2'b01,
        MARK_O = 2'b10
    } cell_t;

    // {R,G,B} on/off masks, widened to C_W bits per channel at the output.
    localparam logic [2:0] COL_BLACK  = 3'b000;
    localparam logic [2:0] COL_WHITE  = 3'b111;
    localparam logic [2:0] COL_RED    = 3'b100;
    localparam logic [2:0] COL_GREEN  = 3'b010;
    localparam logic [2:0] COL_BLUE   = 3'b001;
    localparam logic [2:0] COL_YELLOW = 3'b110;

endpackage

// File: rtl/vga_board_painter_btn_debounce.sv
// Button conditioner: 2-flop synchroniser, stable-count debouncer, rising-edge pulse.
module btn_debounce #(
    parameter int DB_CYC = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic pulse
);
    localparam int CW = $clog2(DB_CYC + 1);

    logic [1:0]    sync_q, sync_d;
    logic          db_q, db_d;
    logic          pulse_q, pulse_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync_d  = {sync_q[0], btn};
        db_d    = db_q;
        cnt_d   = '0;
        pulse_d = 1'b0;
        // Any cycle back at the settled level restarts the count.
        if (sync_q[1] != db_q) begin
            if (cnt_q == CW'(DB_CYC - 1)) begin
                db_d    = sync_q[1];
                pulse_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q  <= '0;
            db_q    <= 1'b0;
            pulse_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= sync_d;
            db_q    <= db_d;
            pulse_q <= pulse_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/vga_board_painter.sv
// 640x480@60 board-game painter: cursor/placement control plus grid rendering.
// Optional VGA_BOARD_WIN_DETECT_EN adds a line scanner, win/draw latch and game_over.
module vga_board_painter
    import vga_board_pkg::*;
#(
    parameter int C_W      = 1,
    parameter int GRID_N   = 3,
    parameter int CELL_PX  = 120,
    parameter int BOARD_X0 = 140,
    parameter int BOARD_Y0 = 60,
    parameter int LINE_PX  = 4,
    parameter int DB_CYC   = 1000000
) (
    input  logic                              clk_100MHz,
    input  logic                              rst_n,
    input  logic                              left,
    input  logic                              right,
    input  logic                              place,
    output logic                              hsync,
    output logic                              vsync,
    output logic [3*C_W-1:0]                  rgb,
    output logic                              video_on,
    output logic [9:0]                        pixel_x,
    output logic [9:0]                        pixel_y,
    output logic [$clog2(GRID_N*GRID_N)-1:0]  cursor_idx,
    output logic                              turn
`ifdef VGA_BOARD_WIN_DETECT_EN
    ,
    output logic                              game_over
`endif
);
    localparam int NCELL   = GRID_N * GRID_N;
    localparam int IDX_W   = $clog2(NCELL);
    localparam int BOARD_W = GRID_N * CELL_PX;
    localparam int INSET   = 16;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NCELL - 1);

    logic left_p, right_p, place_p;

    btn_debounce #(.DB_CYC(DB_CYC)) u_db_left  (.clk(clk_100MHz), .rst_n(rst_n), .btn(left),  .pulse(left_p));
    btn_debounce #(.DB_CYC(DB_CYC)) u_db_right (.clk(clk_100MHz), .rst_n(rst_n), .btn(right), .pulse(right_p));
    btn_debounce #(.DB_CYC(DB_CYC)) u_db_place (.clk(clk_100MHz), .rst_n(rst_n), .btn(place), .pulse(place_p));

    logic [1:0]             div_q, div_d;
    logic [9:0]             h_q, h_d, v_q, v_d;
    logic                   hsync_q, hsync_d, vsync_q, vsync_d, video_on_q, video_on_d;
    logic [3*C_W-1:0]       rgb_q, rgb_d;
    logic [9:0]             pixel_x_q, pixel_x_d, pixel_y_q, pixel_y_d;
    logic [NCELL-1:0][1:0]  board_q, board_d;
    logic [IDX_W-1:0]       cursor_q, cursor_d;
    logic                   turn_q, turn_d;

    logic       tick, vis, hs_on, vs_on, place_ok, frozen;
    logic       win_on, draw_on;
    logic [1:0] win_mark;

    assign tick     = (div_q == 2'd3);
    assign vis      = (h_q < 10'(H_VIS)) && (v_q < 10'(V_VIS));
    assign hs_on    = (h_q >= 10'(H_VIS + H_FP)) && (h_q < 10'(H_VIS + H_FP + H_SP));
    assign vs_on    = (v_q >= 10'(V_VIS + V_FP)) && (v_q < 10'(V_VIS + V_FP + V_SP));
    assign place_ok = place_p && !frozen && (board_q[cursor_q] == EMPTY);

    // Placement uses the pre-move cursor; opposing moves cancel.
    always_comb begin
        board_d  = board_q;
        turn_d   = turn_q;
        cursor_d = cursor_q;
        if (place_ok) begin
            board_d[cursor_q] = turn_q ? MARK_O : MARK_X;
            turn_d            = ~turn_q;
        end
        if (right_p && !left_p)
            cursor_d = (cursor_q == LAST) ? '0 : cursor_q + 1'b1;
        else if (left_p && !right_p)
            cursor_d = (cursor_q == '0) ? LAST : cursor_q - 1'b1;
    end

    int         bx, by, ox, oy, col, row;
    logic [1:0] pix_cell;
    logic       on_board, on_line, on_mark, on_cursor;
    logic [2:0] mask;

    // Cell lookup by comparing against multiples of CELL_PX, no divider.
    always_comb begin
        bx  = int'(h_q) - BOARD_X0;
        by  = int'(v_q) - BOARD_Y0;
        col = 0;
        row = 0;
        ox  = bx;
        oy  = by;
        for (int k = 1; k < GRID_N; k++) begin
            if (bx >= k * CELL_PX) begin
                col = k;
                ox  = bx - k * CELL_PX;
            end
            if (by >= k * CELL_PX) begin
                row = k;
                oy  = by - k * CELL_PX;
            end
        end
        pix_cell = EMPTY;
        for (int i = 0; i < NCELL; i++)
            if (i == row * GRID_N + col) pix_cell = board_q[i];
        on_board  = (bx >= 0) && (bx < BOARD_W) && (by >= 0) && (by < BOARD_W);
        on_line   = (ox < LINE_PX) || (oy < LINE_PX) ||
                    (bx >= BOARD_W - LINE_PX) || (by >= BOARD_W - LINE_PX);
        on_mark   = (ox >= INSET) && (ox < CELL_PX - INSET) &&
                    (oy >= INSET) && (oy < CELL_PX - INSET);
        on_cursor = (int'(cursor_q) == row * GRID_N + col);
        mask      = COL_BLACK;
        if (vis && on_board) begin
            if (on_line) begin
                mask = draw_on ? COL_YELLOW : COL_WHITE;
            end else begin
                if (on_mark && pix_cell == MARK_X)      mask = COL_RED;
                else if (on_mark && pix_cell == MARK_O) mask = COL_BLUE;
                else if (on_cursor)                     mask = COL_GREEN;
                if (win_on && pix_cell == win_mark)     mask = ~mask;
            end
        end
    end

    always_comb begin
        div_d      = div_q + 1'b1;
        h_d        = h_q;
        v_d        = v_q;
        hsync_d    = hsync_q;
        vsync_d    = vsync_q;
        video_on_d = video_on_q;
        rgb_d      = rgb_q;
        pixel_x_d  = pixel_x_q;
        pixel_y_d  = pixel_y_q;
        if (tick) begin
            if (h_q == 10'(H_TOT - 1)) begin
                h_d = '0;
                v_d = (v_q == 10'(V_TOT - 1)) ? '0 : v_q + 10'd1;
            end else begin
                h_d = h_q + 10'd1;
            end
            hsync_d    = ~hs_on;
            vsync_d    = ~vs_on;
            video_on_d = vis;
            pixel_x_d  = h_q;
            pixel_y_d  = v_q;
            rgb_d      = {{C_W{mask[2]}}, {C_W{mask[1]}}, {C_W{mask[0]}}};
        end
    end

`ifdef VGA_BOARD_WIN_DETECT_EN
    localparam int N_LINES = 2 * GRID_N + 2;
    localparam int LN_W    = $clog2(N_LINES);

    logic            scan_q, scan_d, win_q, win_d, draw_q, draw_d;
    logic [LN_W-1:0] line_q, line_d;
    logic [1:0]      winner_q, winner_d, line_mark;
    logic            line_full, board_full;

    // Lines are ordered rows, columns, main diagonal, anti-diagonal.
    function automatic int line_cell(input int l, input int j);
        if (l < GRID_N)          return l * GRID_N + j;
        else if (l < 2 * GRID_N) return j * GRID_N + (l - GRID_N);
        else if (l == 2 * GRID_N) return j * GRID_N + j;
        else                     return j * GRID_N + (GRID_N - 1 - j);
    endfunction

    always_comb begin
        line_mark  = EMPTY;
        line_full  = 1'b1;
        board_full = 1'b1;
        for (int i = 0; i < NCELL; i++) begin
            if (i == line_cell(int'(line_q), 0)) line_mark = board_q[i];
            if (board_q[i] == EMPTY) board_full = 1'b0;
        end
        for (int j = 0; j < GRID_N; j++)
            for (int i = 0; i < NCELL; i++)
                if (i == line_cell(int'(line_q), j) && board_q[i] != line_mark) line_full = 1'b0;
        if (line_mark == EMPTY) line_full = 1'b0;

        scan_d   = scan_q;
        line_d   = line_q;
        win_d    = win_q;
        draw_d   = draw_q;
        winner_d = winner_q;
        if (place_ok) begin
            scan_d = 1'b1;
            line_d = '0;
        end else if (scan_q) begin
            if (line_full) begin
                win_d    = 1'b1;
                winner_d = line_mark;
                scan_d   = 1'b0;
            end else if (line_q == LN_W'(N_LINES - 1)) begin
                scan_d = 1'b0;
                draw_d = board_full;
            end else begin
                line_d = line_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (!rst_n) begin
            scan_q   <= 1'b0;
            line_q   <= '0;
            win_q    <= 1'b0;
            draw_q   <= 1'b0;
            winner_q <= EMPTY;
        end else begin
            scan_q   <= scan_d;
            line_q   <= line_d;
            win_q    <= win_d;
            draw_q   <= draw_d;
            winner_q <= winner_d;
        end
    end

    assign frozen    = win_q | draw_q;
    assign win_on    = win_q;
    assign draw_on   = draw_q;
    assign win_mark  = winner_q;
    assign game_over = win_q | draw_q;
`else
    assign frozen   = 1'b0;
    assign win_on   = 1'b0;
    assign draw_on  = 1'b0;
    assign win_mark = EMPTY;
`endif

    always_ff @(posedge clk_100MHz) begin
        if (!rst_n) begin
            div_q      <= '0;
            h_q        <= '0;
            v_q        <= '0;
            hsync_q    <= 1'b1;
            vsync_q    <= 1'b1;
            video_on_q <= 1'b0;
            rgb_q      <= '0;
            pixel_x_q  <= '0;
            pixel_y_q  <= '0;
            board_q    <= '0;
            cursor_q   <= '0;
            turn_q     <= 1'b0;
        end else begin
            div_q      <= div_d;
            h_q        <= h_d;
            v_q        <= v_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            video_on_q <= video_on_d;
            rgb_q      <= rgb_d;
            pixel_x_q  <= pixel_x_d;
            pixel_y_q  <= pixel_y_d;
            board_q    <= board_d;
            cursor_q   <= cursor_d;
            turn_q     <= turn_d;
        end
    end

    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign rgb        = rgb_q;
    assign video_on   = video_on_q;
    assign pixel_x    = pixel_x_q;
    assign pixel_y    = pixel_y_q;
    assign cursor_idx = cursor_q;
    assign turn       = turn_q;

endmodule
